// File: rtl/psw_pkg.sv
// Shared constants and types for the XM23 PSW unit: op vector bit indices,
// PSW bit positions, CEX condition codes and the CEX phase encoding.
package psw_pkg;

    localparam int unsigned OP_ADD  = 9;
    localparam int unsigned OP_ADDC = 10;
    localparam int unsigned OP_SUB  = 11;
    localparam int unsigned OP_SUBC = 12;
    localparam int unsigned OP_DADD = 13;
    localparam int unsigned OP_CMP  = 14;
    localparam int unsigned OP_XOR  = 15;
    localparam int unsigned OP_AND  = 16;
    localparam int unsigned OP_OR   = 17;
    localparam int unsigned OP_BIT  = 18;
    localparam int unsigned OP_BIC  = 19;
    localparam int unsigned OP_BIS  = 20;
    localparam int unsigned OP_MOV  = 21;
    localparam int unsigned OP_SWAP = 22;
    localparam int unsigned OP_SRA  = 23;
    localparam int unsigned OP_RRC  = 24;
    localparam int unsigned OP_COMP = 25;
    localparam int unsigned OP_SWPB = 26;
    localparam int unsigned OP_SXT  = 27;

    localparam int unsigned PSW_C   = 0;
    localparam int unsigned PSW_Z   = 1;
    localparam int unsigned PSW_N   = 2;
    localparam int unsigned PSW_SLP = 3;
    localparam int unsigned PSW_V   = 4;

    typedef enum logic [3:0] {
        EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, TR, FL
    } cond_e;

    typedef enum logic [1:0] {
        IDLE, TRUE_PH, FALSE_PH
    } cex_state_e;

    function automatic logic eval_cond(input cond_e cond, input logic [4:0] f);
        logic c, z, n, v;
        c = f[PSW_C];
        z = f[PSW_Z];
        n = f[PSW_N];
        v = f[PSW_V];
        case (cond)
            EQ:      eval_cond = z;
            NE:      eval_cond = ~z;
            CS:      eval_cond = c;
            CC:      eval_cond = ~c;
            MI:      eval_cond = n;
            PL:      eval_cond = ~n;
            VS:      eval_cond = v;
            VC:      eval_cond = ~v;
            HI:      eval_cond = c & ~z;
            LS:      eval_cond = ~c | z;
            GE:      eval_cond = (n == v);
            LT:      eval_cond = (n != v);
            GT:      eval_cond = ~z & (n == v);
            LE:      eval_cond = z | (n != v);
            TR:      eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/psw_unit_cex_fsm.sv
// CEX conditional-execution sequencer: true/false block counters, phase state
// and the exec_ok gate for writeback and PSW updates.
module cex_fsm
    import psw_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             step_i,
    input  logic             start_i,
    input  logic             cond_i,
    input  logic [CNT_W-1:0] tc_i,
    input  logic [CNT_W-1:0] fc_i,
    output logic             exec_ok_o
);

    cex_state_e       state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             cond_q, cond_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            fcnt_q  <= '0;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            fcnt_q  <= fcnt_d;
            cond_q  <= cond_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        fcnt_d    = fcnt_q;
        cond_d    = cond_q;
        exec_ok_o = 1'b1;

        unique case (state_q)
            TRUE_PH:  exec_ok_o = cond_q;
            FALSE_PH: exec_ok_o = ~cond_q;
            default:  exec_ok_o = 1'b1;
        endcase

        // An executed CEX restarts the sequence; otherwise every issued slot,
        // executed or skipped, consumes one count of the active block.
        if (start_i) begin
            cond_d = cond_i;
            tcnt_d = tc_i;
            fcnt_d = fc_i;
            if (tc_i != '0) begin
                state_d = TRUE_PH;
            end else if (fc_i != '0) begin
                state_d = FALSE_PH;
            end else begin
                state_d = IDLE;
            end
        end else if (step_i) begin
            case (state_q)
                TRUE_PH: begin
                    tcnt_d = tcnt_q - CNT_W'(1);
                    if (tcnt_q <= CNT_W'(1)) begin
                        tcnt_d  = '0;
                        state_d = (fcnt_q != '0) ? FALSE_PH : IDLE;
                    end
                end
                FALSE_PH: begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                    if (fcnt_q <= CNT_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/psw_unit.sv
// XM23 PSW holder and flag datapath for the execute stage, with CEX gating.
// Optional macro PSW_SHIFT_FLAGS_EN: SRA/RRC update C/N/Z even when psw_msk is low.
module psw_unit
    import psw_pkg::*;
#(
    parameter int unsigned OP_W  = 41,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic [OP_W-1:0]  op_en_i,
    input  logic [15:0]      a_i,
    input  logic [15:0]      b_i,
    input  logic [15:0]      result_i,
    input  logic             psw_msk_i,
    input  logic             setcc_i,
    input  logic             clrcc_i,
    input  logic [4:0]       cc_mask_i,
    input  logic             psw_wr_i,
    input  logic [15:0]      psw_wdata_i,
    input  logic             cex_start_i,
    input  logic [3:0]       cex_cond_i,
    input  logic [CNT_W-1:0] cex_tc_i,
    input  logic [CNT_W-1:0] cex_fc_i,
    output logic [15:0]      psw_o,
    output logic             carry_out_o,
    output logic             exec_ok_o
);

    logic [4:0]  flags_q, flags_d;
    logic        exec_ok;
    logic        step, acc;
    logic        cond_true;
    logic [15:0] b_eff;
    logic        ci;
    logic        arith;
    logic [16:0] sum;
    logic        v_arith;
    logic        dadd_c;
    logic        unused_bits;

    assign unused_bits = ^{psw_wdata_i[15:5], op_en_i};

    assign step = valid_i & ~stall_i;
    assign acc  = step & exec_ok;

    always_comb begin
        b_eff = b_i;
        ci    = 1'b0;
        arith = 1'b0;
        if (op_en_i[OP_ADD]) begin
            arith = 1'b1;
        end else if (op_en_i[OP_ADDC]) begin
            arith = 1'b1;
            ci    = flags_q[PSW_C];
        end else if (op_en_i[OP_SUB] | op_en_i[OP_CMP]) begin
            arith = 1'b1;
            b_eff = ~b_i;
            ci    = 1'b1;
        end else if (op_en_i[OP_SUBC]) begin
            arith = 1'b1;
            b_eff = ~b_i;
            ci    = flags_q[PSW_C];
        end
    end

    assign sum     = {1'b0, a_i} + {1'b0, b_eff} + {16'b0, ci};
    assign v_arith = (a_i[15] == b_eff[15]) & (result_i[15] != a_i[15]);

    // BCD carry chain: a nibble carries out whenever its decimal sum exceeds 9.
    always_comb begin : dadd_chain
        logic [4:0] nib;
        dadd_c = flags_q[PSW_C];
        nib    = '0;
        for (int i = 0; i < 4; i++) begin
            nib    = {1'b0, a_i[4*i +: 4]} + {1'b0, b_i[4*i +: 4]} + {4'b0, dadd_c};
            dadd_c = (nib > 5'd9);
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (acc) begin
            if (psw_wr_i) begin
                flags_d = psw_wdata_i[4:0];
            end else if (clrcc_i) begin
                flags_d = flags_q & ~cc_mask_i;
            end else if (setcc_i) begin
                flags_d = flags_q | cc_mask_i;
            end else if (psw_msk_i) begin
                flags_d[PSW_N] = result_i[15];
                flags_d[PSW_Z] = (result_i == 16'h0000);
                if (arith) begin
                    flags_d[PSW_C] = sum[16];
                    flags_d[PSW_V] = v_arith;
                end else if (op_en_i[OP_DADD]) begin
                    flags_d[PSW_C] = dadd_c;
                end
`ifdef PSW_SHIFT_FLAGS_EN
                if (op_en_i[OP_SRA] | op_en_i[OP_RRC]) begin
                    flags_d[PSW_C] = a_i[0];
                end
            end else if (op_en_i[OP_SRA] | op_en_i[OP_RRC]) begin
                flags_d[PSW_C] = a_i[0];
                flags_d[PSW_N] = result_i[15];
                flags_d[PSW_Z] = (result_i == 16'h0000);
            end
`else
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign cond_true = eval_cond(cond_e'(cex_cond_i), flags_q);

    cex_fsm #(
        .CNT_W (CNT_W)
    ) u_cex_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .step_i    (step),
        .start_i   (acc & cex_start_i),
        .cond_i    (cond_true),
        .tc_i      (cex_tc_i),
        .fc_i      (cex_fc_i),
        .exec_ok_o (exec_ok)
    );

    assign psw_o       = {11'b0, flags_q};
    assign carry_out_o = flags_q[PSW_C];
    assign exec_ok_o   = exec_ok;

endmodule

// File: tb/tb_psw_unit.sv
// Self-checking bench for psw_unit: directed vector table, CEX/reset sequences
// and randomized traffic against a queue-based reference model.
module tb_psw_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        stall;
    logic [40:0] op_en;
    logic [15:0] a, b, result;
    logic        psw_msk;
    logic        setcc, clrcc;
    logic [4:0]  cc_mask;
    logic        psw_wr;
    logic [15:0] psw_wdata;
    logic        cex_start;
    logic [3:0]  cex_cond;
    logic [2:0]  tc, fc;
    logic [15:0] psw;
    logic        carry_out;
    logic        exec_ok;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_op   = -1;

    // Reference model: flags plus a queue of per-slot exec_ok values for the CEX block.
    logic [4:0] m_flags = '0;
    logic       m_q[$];

    always #5 clk = ~clk;

    psw_unit #(
        .OP_W  (41),
        .CNT_W (3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .stall_i     (stall),
        .op_en_i     (op_en),
        .a_i         (a),
        .b_i         (b),
        .result_i    (result),
        .psw_msk_i   (psw_msk),
        .setcc_i     (setcc),
        .clrcc_i     (clrcc),
        .cc_mask_i   (cc_mask),
        .psw_wr_i    (psw_wr),
        .psw_wdata_i (psw_wdata),
        .cex_start_i (cex_start),
        .cex_cond_i  (cex_cond),
        .cex_tc_i    (tc),
        .cex_fc_i    (fc),
        .psw_o       (psw),
        .carry_out_o (carry_out),
        .exec_ok_o   (exec_ok)
    );

    function automatic logic m_ok();
        return (m_q.size() == 0) ? 1'b1 : m_q[0];
    endfunction

    function automatic logic m_cond(input int code, input logic [4:0] f);
        logic c, z, n, v;
        c = f[0]; z = f[1]; n = f[2]; v = f[4];
        case (code)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clock();
        logic ok, stp, acc, cnd;
        logic [4:0] f;
        int ai, bi, bp, ci, s, c, t;
        if (rst) begin
            m_flags = '0;
            m_q.delete();
            return;
        end
        ok  = m_ok();
        stp = valid && !stall;
        acc = stp && ok;
        cnd = m_cond(int'(cex_cond), m_flags);
        f   = m_flags;
        ai  = int'(a);
        bi  = int'(b);
        if (acc) begin
            if (psw_wr) f = psw_wdata[4:0];
            else if (clrcc) f = f & ~cc_mask;
            else if (setcc) f = f | cc_mask;
            else if (psw_msk) begin
                f[2] = result[15];
                f[1] = (result == 0);
                if (cur_op inside {9, 10, 11, 12, 14}) begin
                    bp = (cur_op == 9 || cur_op == 10) ? bi : 65535 - bi;
                    ci = (cur_op == 9) ? 0 : (cur_op == 11 || cur_op == 14) ? 1 : int'(m_flags[0]);
                    s  = ai + bp + ci;
                    f[0] = (s > 65535);
                    f[4] = (((ai >> 15) & 1) == ((bp >> 15) & 1)) && (result[15] != a[15]);
                end else if (cur_op == 13) begin
                    c = int'(m_flags[0]);
                    for (int i = 0; i < 4; i++) begin
                        t = ((ai >> (4 * i)) & 15) + ((bi >> (4 * i)) & 15) + c;
                        c = (t > 9) ? 1 : 0;
                    end
                    f[0] = (c == 1);
                end
`ifdef PSW_SHIFT_FLAGS_EN
                if (cur_op == 23 || cur_op == 24) f[0] = a[0];
            end else if (cur_op == 23 || cur_op == 24) begin
                f[0] = a[0];
                f[2] = result[15];
                f[1] = (result == 0);
            end
`else
            end
`endif
        end
        m_flags = f;
        if (acc && cex_start) begin
            m_q.delete();
            repeat (tc) m_q.push_back(cnd);
            repeat (fc) m_q.push_back(!cnd);
        end else if (stp && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic set_op(input int op);
        cur_op = op;
        op_en  = (op >= 0) ? (41'd1 << op) : '0;
    endtask

    task automatic set_idle();
        rst = 0; valid = 0; stall = 0; set_op(-1);
        a = 0; b = 0; result = 0; psw_msk = 0;
        setcc = 0; clrcc = 0; cc_mask = 0; psw_wr = 0; psw_wdata = 0;
        cex_start = 0; cex_cond = 0; tc = 0; fc = 0;
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          op;
        logic [15:0] a, b, res;
        logic        msk, sc, cc, wr;
        logic [4:0]  mask;
        logic [15:0] wdata;
        logic [4:0]  exp;
    } vec_t;

    vec_t vt[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{9,  16'h7FFF, 16'h0001, 16'h8000, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h14};
        vt[1]  = '{11, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h03};
        vt[2]  = '{10, 16'h0001, 16'h0001, 16'h0003, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h00};
        vt[3]  = '{13, 16'h9999, 16'h0001, 16'h0000, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h03};
        vt[4]  = '{16, 16'hFFFF, 16'h8000, 16'h8000, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h05};
        vt[5]  = '{21, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0, 0, 5'h00, 16'h0000, 5'h05};
        vt[6]  = '{9,  16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 5'h1F, 16'h0000, 5'h1F};
        vt[7]  = '{-1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1, 0, 5'h0A, 16'h0000, 5'h15};
        vt[8]  = '{14, 16'h8000, 16'h0001, 16'h7FFF, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h11};
        vt[9]  = '{12, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 5'h00, 16'h0000, 5'h03};
        vt[10] = '{-1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 1, 5'h1F, 16'hFFE8, 5'h08};

        set_idle();
        rst = 1;
        cycle();
        cycle();
        check("reset psw", psw, 16'h0000);
        check("reset carry", {15'b0, carry_out}, 16'h0000);
        check("reset exec_ok", {15'b0, exec_ok}, 16'h0001);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            set_idle();
            valid = 1;
            set_op(vt[i].op);
            a = vt[i].a; b = vt[i].b; result = vt[i].res;
            psw_msk = vt[i].msk; setcc = vt[i].sc; clrcc = vt[i].cc; psw_wr = vt[i].wr;
            cc_mask = vt[i].mask; psw_wdata = vt[i].wdata;
            cycle();
            check($sformatf("vec%0d psw", i), psw, {11'b0, vt[i].exp});
            check($sformatf("vec%0d carry", i), {15'b0, carry_out}, {15'b0, vt[i].exp[0]});
        end

        // CEX EQ with Z=1, tc=2 fc=1, one stall mid-block, skipped setcc at the end.
        set_idle(); valid = 1; setcc = 1; cc_mask = 5'h02;
        cycle();
        set_idle(); valid = 1; cex_start = 1; cex_cond = 4'd0; tc = 3'd2; fc = 3'd1;
        cycle();
        check("cex slot1 ok", {15'b0, exec_ok}, 16'h0001);
        set_idle(); valid = 1;
        cycle();
        check("cex slot2 ok", {15'b0, exec_ok}, 16'h0001);
        set_idle(); valid = 1; stall = 1;
        cycle();
        check("cex stall hold", {15'b0, exec_ok}, 16'h0001);
        set_idle(); valid = 1;
        cycle();
        check("cex slot3 ok", {15'b0, exec_ok}, 16'h0000);
        set_idle(); valid = 1; setcc = 1; cc_mask = 5'h1F;
        cycle();
        check("cex back idle", {15'b0, exec_ok}, 16'h0001);
        check("skipped psw", psw, 16'h000A);

        // Reset in the middle of a TRUE phase with a false condition.
        set_idle(); valid = 1; setcc = 1; cc_mask = 5'h15;
        cycle();
        check("setcc merge", psw, 16'h001F);
        set_idle(); valid = 1; cex_start = 1; cex_cond = 4'd15; tc = 3'd5;
        cycle();
        check("cex fl skip", {15'b0, exec_ok}, 16'h0000);
        set_idle(); valid = 1; rst = 1;
        cycle();
        rst = 0;
        check("midblk rst psw", psw, 16'h0000);
        check("midblk rst carry", {15'b0, carry_out}, 16'h0000);
        check("midblk rst ok", {15'b0, exec_ok}, 16'h0001);

        set_idle(); valid = 1; set_op(24); a = 16'h0001; result = 16'h0000;
        cycle();
`ifdef PSW_SHIFT_FLAGS_EN
        check("rrc flags", psw, 16'h0003);
`else
        check("rrc no flags", psw, 16'h0000);
`endif

        for (int n = 0; n < 3000; n++) begin
            int r;
            set_idle();
            rst   = ($urandom % 300) == 0;
            valid = ($urandom % 4) != 0;
            stall = ($urandom % 8) == 0;
            r = $urandom % 10;
            if (r < 8) set_op($urandom_range(9, 27));
            else if (r == 8) set_op(-1);
            else set_op($urandom_range(0, 40));
            a = 16'($urandom);
            b = 16'($urandom);
            result = (($urandom % 8) == 0) ? 16'h0000 : 16'($urandom);
            psw_msk = ($urandom % 4) != 0;
            setcc = ($urandom % 16) == 0;
            clrcc = ($urandom % 16) == 0;
            cc_mask = 5'($urandom);
            psw_wr = ($urandom % 32) == 0;
            psw_wdata = 16'($urandom);
            cex_start = ($urandom % 8) == 0;
            cex_cond = 4'($urandom);
            tc = 3'($urandom_range(0, 3));
            fc = 3'($urandom_range(0, 3));
            cycle();
            check("rand psw", psw, {11'b0, m_flags});
            check("rand carry", {15'b0, carry_out}, {15'b0, m_flags[0]});
            check("rand exec_ok", {15'b0, exec_ok}, {15'b0, m_ok()});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
